// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath width, reset vector default and the
// fetch packet handed from fetch to decode.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect inputs and the
// decode-side valid/ready handshake.
interface fetch_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            br_taken;
  logic [XLEN-1:0] br_target;
  logic            jmp_taken;
  logic [XLEN-1:0] jmp_target;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc_plus4;
  logic            misalign;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4, misalign,
    input  imem_rdata, br_taken, br_target, jmp_taken, jmp_target, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4, misalign,
    output imem_rdata, br_taken, br_target, jmp_taken, jmp_target, dec_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch packets; flush dominates push, head reads
// as all-zero while empty.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fetch_pkt_t                 pkt_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_pkt_t                 head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_pkt_t    mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty_o = (cnt_q == '0);
    full_o  = (cnt_q == CW'(DEPTH));
    count_o = cnt_q;
    do_pop  = pop_i && !empty_o;
    // A pop frees the head slot in the same cycle, so a full queue may still accept a push.
    do_push = push_i && (!full_o || do_pop);
    head_o  = empty_o ? '0 : mem_q[rd_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= pkt_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem request with
// credit-based issue, prioritised redirect with flush, misalign flag.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
  parameter int unsigned     QDEPTH   = 2
) (
  input logic         clk,
  input logic         reset_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CW    = $clog2(QDEPTH + 1);
  localparam int unsigned CREDW = CW + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic             misalign_q, misalign_d;
  logic             redirect, issue, push, pop;
  logic [XLEN-1:0]  redirect_tgt;
  logic [CREDW-1:0] credit;
  fetch_pkt_t       push_pkt, head_pkt;
  logic             q_full, q_empty;
  logic [CW-1:0]    q_count;

  always_comb begin
    redirect     = bus.br_taken || bus.jmp_taken;
    redirect_tgt = bus.br_taken ? bus.br_target : bus.jmp_target;
    pop          = !q_empty && bus.dec_ready;
    // Occupancy after this cycle's pop plus the outstanding response; this lets
    // a 2-entry queue issue every cycle while decode keeps draining.
    credit       = CREDW'(q_count) + CREDW'(inflight_q) - CREDW'(pop);
    issue        = reset_n && !redirect && (credit < CREDW'(QDEPTH));
    // A response returning during a redirect belongs to the abandoned path.
    push         = inflight_q && !redirect;

    push_pkt.pc       = inflight_pc_q;
    push_pkt.pc_plus4 = inflight_pc_q + XLEN'(4);
    push_pkt.instr    = bus.imem_rdata;

    pc_d = pc_q;
    if (redirect)   pc_d = {redirect_tgt[XLEN-1:2], 2'b00};
    else if (issue) pc_d = pc_q + XLEN'(4);

    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    misalign_d    = redirect && (redirect_tgt[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .pkt_i   (push_pkt),
    .pop_i   (pop),
    .flush_i (redirect),
    .head_o  (head_pkt),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign bus.imem_req     = issue;
  assign bus.imem_addr    = pc_q;
  assign bus.dec_valid    = !q_empty;
  assign bus.dec_instr    = head_pkt.instr;
  assign bus.dec_pc       = head_pkt.pc;
  assign bus.dec_pc_plus4 = head_pkt.pc_plus4;
  assign bus.misalign     = misalign_q;

  // The issue credit must never let a response land in a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && q_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scoreboarded decode stream, redirect
// vector table and hand-written reset / stall / back-to-back redirect cases.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic fetched_300 = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();
  fetch_unit_if #(.XLEN(32)) busw ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .QDEPTH(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) u_dutw (
    .clk(clk), .reset_n(reset_n), .bus(busw));

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Synchronous instruction memories, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= memf(bus.imem_addr);
    if (busw.imem_req) busw.imem_rdata <= memf(busw.imem_addr);
    if (bus.imem_req && bus.imem_addr[31:4] == 28'h000_0030) fetched_300 <= 1'b1;
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;

  typedef struct {
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc;
    refill();
  endtask

  // Sample point: negedge; every accepted head is compared with the scoreboard.
  task automatic neg();
    logic [31:0] e;
    @(negedge clk);
    if (bus.dec_valid && bus.dec_ready) begin
      refill();
      e = exp_q.pop_front();
      chk("pop_pc", bus.dec_pc, e);
      chk("pop_pc4", bus.dec_pc_plus4, e + 32'd4);
      chk("pop_instr", bus.dec_instr, memf(e));
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      neg();
      pos();
    end
  endtask

  task automatic redirect_seq(input vec_t v);
    bus.br_taken   = v.br;
    bus.br_target  = v.bt;
    bus.jmp_taken  = v.jmp;
    bus.jmp_target = v.jt;
    neg();
    chk("R_req", bus.imem_req, 1'b0);
    pos();
    bus.br_taken  = 1'b0;
    bus.jmp_taken = 1'b0;
    restart_stream(v.exp_pc);
    neg();
    chk("R1_misalign", bus.misalign, v.exp_mis);
    chk("R1_addr", bus.imem_addr, v.exp_pc);
    chk("R1_req", bus.imem_req, 1'b1);
    chk("R1_valid", bus.dec_valid, 1'b0);
    pos();
    neg();
    chk("R2_valid", bus.dec_valid, 1'b0);
    chk("R2_misalign", bus.misalign, 1'b0);
    pos();
    neg();
    chk("R3_valid", bus.dec_valid, 1'b1);
    chk("R3_pc", bus.dec_pc, v.exp_pc);
    pos();
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 32'h0000_0200, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0102, 32'h0000_0100, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_1003, 1'b0, 32'h0000_0000, 32'h0000_1000, 1'b1};
    vecs[4] = '{1'b1, 32'hFFFF_FFF8, 1'b1, 32'h0000_0304, 32'hFFFF_FFF8, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0081, 1'b0, 32'h0000_0000, 32'h0000_0080, 1'b1};

    bus.br_taken = 1'b0;  bus.br_target = '0;  bus.jmp_taken = 1'b0;  bus.jmp_target = '0;
    bus.dec_ready = 1'b1;
    busw.br_taken = 1'b0; busw.br_target = '0; busw.jmp_taken = 1'b0; busw.jmp_target = '0;
    busw.dec_ready = 1'b1;
    restart_stream(32'h0);

    #1 reset_n = 1'b0;
    #2;
    chk("rst_valid", bus.dec_valid, 1'b0);
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_pc", bus.dec_pc, 32'h0);
    chk("rst_instr", bus.dec_instr, 32'h0);
    chk("rst_misalign", bus.misalign, 1'b0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rstw_addr", busw.imem_addr, 32'hFFFF_FFFC);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Startup: issue in cycle 0, first packet on decode in cycle 2, then one per cycle.
    neg();
    chk("c0_req", bus.imem_req, 1'b1);
    chk("c0_addr", bus.imem_addr, 32'h0);
    chk("c0_valid", bus.dec_valid, 1'b0);
    pos();
    neg();
    chk("c1_valid", bus.dec_valid, 1'b0);
    chk("c1_addr", bus.imem_addr, 32'h4);
    pos();
    neg();
    chk("c2_valid", bus.dec_valid, 1'b1);
    chk("c2_pc", bus.dec_pc, 32'h0);
    pos();
    for (int i = 0; i < 8; i++) begin
      neg();
      chk("stream_valid", bus.dec_valid, 1'b1);
      pos();
    end

    // Backpressure: queue fills, requests stop, order preserved on release.
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      neg();
      chk("stall_req", bus.imem_req, 1'b0);
      chk("stall_valid", bus.dec_valid, 1'b1);
      pos();
    end
    bus.dec_ready = 1'b1;
    step(6);

    // Branch into a full queue.
    bus.dec_ready = 1'b0;
    step(3);
    redirect_seq('{1'b1, 32'h0000_0100, 1'b0, 32'h0, 32'h0000_0100, 1'b0});
    bus.dec_ready = 1'b1;
    step(4);

    for (int i = 0; i < 6; i++) begin
      redirect_seq(vecs[i]);
      step(3);
    end
    chk("no_fetch_300", fetched_300, 1'b0);

    // Back-to-back redirects: the later one wins, 0x500 never reaches decode.
    bus.br_taken = 1'b1; bus.br_target = 32'h0000_0500;
    neg();
    pos();
    bus.br_taken = 1'b0; bus.jmp_taken = 1'b1; bus.jmp_target = 32'h0000_0600;
    neg();
    chk("bb_R1_req", bus.imem_req, 1'b0);
    chk("bb_R1_valid", bus.dec_valid, 1'b0);
    pos();
    bus.jmp_taken = 1'b0;
    restart_stream(32'h0000_0600);
    neg();
    chk("bb_addr", bus.imem_addr, 32'h0000_0600);
    chk("bb_valid2", bus.dec_valid, 1'b0);
    pos();
    neg();
    chk("bb_valid3", bus.dec_valid, 1'b0);
    pos();
    neg();
    chk("bb_valid4", bus.dec_valid, 1'b1);
    chk("bb_pc", bus.dec_pc, 32'h0000_0600);
    pos();
    step(4);

    // Asynchronous reset mid-stream, then restart; wide instance wraps to 0.
    reset_n = 1'b0;
    #2;
    chk("async_valid", bus.dec_valid, 1'b0);
    chk("async_req", bus.imem_req, 1'b0);
    chk("async_pc", bus.dec_pc, 32'h0);
    chk("asyncw_valid", busw.dec_valid, 1'b0);
    restart_stream(32'h0);
    pos();
    pos();
    reset_n = 1'b1;
    neg();
    chk("rr_addr", bus.imem_addr, 32'h0);
    chk("rr_req", bus.imem_req, 1'b1);
    chk("rrw_addr0", busw.imem_addr, 32'hFFFF_FFFC);
    pos();
    neg();
    chk("rrw_addr1", busw.imem_addr, 32'h0);
    chk("rrw_valid1", busw.dec_valid, 1'b0);
    pos();
    neg();
    chk("rr_valid", bus.dec_valid, 1'b1);
    chk("rrw_pc0", busw.dec_pc, 32'hFFFF_FFFC);
    chk("rrw_pc4_0", busw.dec_pc_plus4, 32'h0);
    chk("rrw_instr0", busw.dec_instr, memf(32'hFFFF_FFFC));
    pos();
    neg();
    chk("rrw_pc1", busw.dec_pc, 32'h0);
    chk("rrw_instr1", busw.dec_instr, memf(32'h0));
    pos();
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
